// File: rtl/maze_dfs_if.sv
// maze_dfs_if -- connects the maze carver to its LIFO, its wall-removal
// consumer and its status/control.
// master: the carver side. slave: the environment (LIFO, wall store, control).
interface maze_dfs_if;
    logic        start;
    logic        stk_push;
    logic        stk_pop;
    logic [7:0]  stk_din;
    logic [7:0]  stk_dout;
    logic        stk_empty;
    logic        stk_full;
    logic        wr_valid;
    logic [3:0]  wr_x;
    logic [3:0]  wr_y;
    logic [1:0]  wr_dir;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cycles;

    modport master (
        input  start, stk_dout, stk_empty, stk_full,
        output stk_push, stk_pop, stk_din,
        output wr_valid, wr_x, wr_y, wr_dir,
        output busy, done, err, cycles
    );

    modport slave (
        output start, stk_dout, stk_empty, stk_full,
        input  stk_push, stk_pop, stk_din,
        input  wr_valid, wr_x, wr_y, wr_dir,
        input  busy, done, err, cycles
    );
endinterface

// File: rtl/maze_dfs.sv
// maze_dfs -- randomised depth-first maze carver over a COLS x ROWS grid.
// Walks from cell (0,0), emitting one wall-removal strobe per carved passage
// and using an external LIFO for backtracking.
// Optional build macro MAZE_DFS_CYCLES_EN: when defined, `cycles` counts busy
// cycles of the current run (saturating); otherwise `cycles` is tied to zero.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   INIT  | mark the origin cell visited
//   PICK  | carve towards a random unvisited neighbour, or backtrack
//   POPW  | wait for the LIFO's registered read data
//   LOAD  | resume from the popped cell
//   DONE  | maze complete, waiting for a new start
//   ERR   | LIFO overflowed; leaves only through reset
module maze_dfs #(
    parameter int         COLS = 8,
    parameter int         ROWS = 8,
    parameter logic [7:0] SEED = 8'hA5
) (
    input logic        clk,
    input logic        rst,
    maze_dfs_if.master bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [2:0] {IDLE, INIT, PICK, POPW, LOAD, DONE, ERR} state_t;

    state_t           state;
    logic [3:0]       cur_x;
    logic [3:0]       cur_y;
    logic [CELLS-1:0] visited;
    logic [7:0]       lfsr;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [3:0]       mask;
    logic [1:0]       dir;
    logic [1:0]       cand;
    logic             found;
    logic [3:0]       nx;
    logic [3:0]       ny;
    logic [IW-1:0]    nidx;
    logic             can_push;
    logic             can_pop;

    // A cell is a candidate only if it lies inside the grid and is not yet carved.
    function automatic logic is_free(input int x, input int y);
        logic f;
        f = 1'b0;
        if (x >= 0 && x < COLS && y >= 0 && y < ROWS)
            f = !visited[IW'(y * COLS + x)];
        return f;
    endfunction

    // Neighbour mask, random direction choice and the resulting strobes for PICK.
    always_comb begin
        mask[0] = is_free(int'(cur_x), int'(cur_y) - 1);
        mask[1] = is_free(int'(cur_x) + 1, int'(cur_y));
        mask[2] = is_free(int'(cur_x), int'(cur_y) + 1);
        mask[3] = is_free(int'(cur_x) - 1, int'(cur_y));

        dir   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = lfsr[1:0] + 2'(k);
            if (!found && mask[cand]) begin
                dir   = cand;
                found = 1'b1;
            end
        end

        nx = cur_x;
        ny = cur_y;
        case (dir)
            2'd0:    ny = cur_y - 4'd1;
            2'd1:    nx = cur_x + 4'd1;
            2'd2:    ny = cur_y + 4'd1;
            default: nx = cur_x - 4'd1;
        endcase
        nidx = IW'(int'(ny) * COLS + int'(nx));

        can_push = (state == PICK) && (mask != 4'd0) && !bus.stk_full;
        can_pop  = (state == PICK) && (mask == 4'd0) && !bus.stk_empty;
    end

    // Main sequencer: state, current cell, visited bitmap and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_x   <= 4'd0;
            cur_y   <= 4'd0;
            visited <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        visited <= '0;
                        cur_x   <= 4'd0;
                        cur_y   <= 4'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    visited[0] <= 1'b1;
                    state      <= PICK;
                end
                PICK: begin
                    if (mask != 4'd0) begin
                        if (bus.stk_full) begin
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                            state  <= ERR;
                        end else begin
                            cur_x         <= nx;
                            cur_y         <= ny;
                            visited[nidx] <= 1'b1;
                        end
                    end else if (!bus.stk_empty) begin
                        state <= POPW;
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                POPW: state <= LOAD;
                LOAD: begin
                    cur_x <= bus.stk_dout[3:0];
                    cur_y <= bus.stk_dout[7:4];
                    state <= PICK;
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

`ifdef MAZE_DFS_CYCLES_EN
    logic [15:0] cycles_q;

    // Run-length counter: restarts on an accepted start, counts busy cycles, saturates.
    always_ff @(posedge clk) begin
        if (rst)
            cycles_q <= 16'h0000;
        else if (bus.start && (state == IDLE || state == DONE))
            cycles_q <= 16'h0000;
        else if (busy_q && cycles_q != 16'hFFFF)
            cycles_q <= cycles_q + 16'd1;
    end

    assign bus.cycles = cycles_q;
`else
    assign bus.cycles = 16'h0000;
`endif

    assign bus.stk_push = can_push;
    assign bus.stk_pop  = can_pop;
    assign bus.stk_din  = {cur_y, cur_x};
    assign bus.wr_valid = can_push;
    assign bus.wr_x     = cur_x;
    assign bus.wr_y     = cur_y;
    assign bus.wr_dir   = dir;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_maze_dfs.sv
// tb_maze_dfs -- scoreboard bench for maze_dfs: a 1x1, a 4x1 and a 4x4 instance,
// each with its own LIFO model; monitors compare strobes against queued or
// model-derived expectations.
module tb_maze_dfs;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

`ifdef MAZE_DFS_CYCLES_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    maze_dfs_if one_if();
    maze_dfs_if row_if();
    maze_dfs_if sq_if();

    maze_dfs #(.COLS(1), .ROWS(1)) u_one (.clk(clk), .rst(rst), .bus(one_if));
    maze_dfs #(.COLS(4), .ROWS(1)) u_row (.clk(clk), .rst(rst), .bus(row_if));
    maze_dfs #(.COLS(4), .ROWS(4)) u_sq  (.clk(clk), .rst(rst), .bus(sq_if));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 1x1 never has a neighbour, so its LIFO is simply an always-empty stub.
    assign one_if.stk_empty = 1'b1;
    assign one_if.stk_full  = 1'b0;
    assign one_if.stk_dout  = 8'h00;

    logic [7:0] row_mem [32];
    logic [4:0] row_cnt;
    logic [7:0] row_dout;
    logic [7:0] sq_mem [32];
    logic [4:0] sq_cnt;
    logic [7:0] sq_dout;
    logic [4:0] sq_depth;
    logic [7:0] ref_lfsr;

    // LIFO model for the 4x1 instance, depth 16, registered read data.
    always @(posedge clk) begin
        if (rst) row_cnt <= 5'd0;
        else if (row_if.stk_push && row_cnt < 5'd16) begin
            row_mem[row_cnt] <= row_if.stk_din;
            row_cnt          <= row_cnt + 5'd1;
        end else if (row_if.stk_pop && row_cnt != 5'd0) begin
            row_dout <= row_mem[row_cnt - 5'd1];
            row_cnt  <= row_cnt - 5'd1;
        end
    end
    assign row_if.stk_dout  = row_dout;
    assign row_if.stk_empty = (row_cnt == 5'd0);
    assign row_if.stk_full  = (row_cnt == 5'd16);

    // LIFO model for the 4x4 instance with a bench-selectable depth.
    always @(posedge clk) begin
        if (rst) sq_cnt <= 5'd0;
        else if (sq_if.stk_push && sq_cnt < sq_depth) begin
            sq_mem[sq_cnt] <= sq_if.stk_din;
            sq_cnt         <= sq_cnt + 5'd1;
        end else if (sq_if.stk_pop && sq_cnt != 5'd0) begin
            sq_dout <= sq_mem[sq_cnt - 5'd1];
            sq_cnt  <= sq_cnt - 5'd1;
        end
    end
    assign sq_if.stk_dout  = sq_dout;
    assign sq_if.stk_empty = (sq_cnt == 5'd0);
    assign sq_if.stk_full  = (sq_cnt == sq_depth);

    // Reference LFSR from the polynomial, shares reset with every DUT.
    always @(posedge clk) begin
        if (rst) ref_lfsr <= 8'hA5;
        else     ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end

    int one_wr = 0, one_push = 0, one_pop = 0;
    int row_push = 0, row_pop = 0;
    int sq_wr = 0, sq_push = 0, sq_pop = 0;
    int row_exp[$];
    int sq_exp[$];
    int sq_rec[$];
    bit sq_recording = 1'b0;
    bit sq_vis [16];

    // 1x1 monitor: any strobe is counted and later expected to be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (one_if.wr_valid) one_wr++;
            if (one_if.stk_push) one_push++;
            if (one_if.stk_pop)  one_pop++;
        end
    end

    // 4x1 monitor: each wall-removal strobe is matched against the queued vector.
    always @(negedge clk) begin : mon_row
        int act;
        if (!rst) begin
            if (row_if.stk_push) row_push++;
            if (row_if.stk_pop)  row_pop++;
            if (row_if.wr_valid) begin
                act = (int'(row_if.wr_x) << 6) | (int'(row_if.wr_y) << 2) | int'(row_if.wr_dir);
                if (row_exp.size() == 0) chk("row_extra_wr", act, -1);
                else                     chk("row_wr", act, row_exp.pop_front());
            end
        end
    end

    // 4x4 monitor: strobe rules, random-direction model, distinct targets, replay.
    always @(negedge clk) begin : mon_sq
        int x, y, tx, ty, ed, c, act, fresh;
        logic [3:0] m;
        if (!rst) begin
            if (sq_if.stk_push || sq_if.stk_pop || sq_if.wr_valid) begin
                chk("sq_push_pop_excl", int'(sq_if.stk_push && sq_if.stk_pop), 0);
                chk("sq_push_eq_wr", int'(sq_if.stk_push), int'(sq_if.wr_valid));
                chk("sq_strobe_busy", int'(sq_if.busy), 1);
            end
            if (sq_if.stk_push) sq_push++;
            if (sq_if.stk_pop)  sq_pop++;
            if (sq_if.wr_valid) begin
                sq_wr++;
                x = int'(sq_if.wr_x);
                y = int'(sq_if.wr_y);
                chk("sq_src_visited", (x < 4 && y < 4) ? int'(sq_vis[y * 4 + x]) : 0, 1);
                m = 4'b0000;
                if (y > 0 && x < 4 && !sq_vis[(y - 1) * 4 + x]) m[0] = 1'b1;
                if (x < 3 && y < 4 && !sq_vis[y * 4 + x + 1])   m[1] = 1'b1;
                if (y < 3 && x < 4 && !sq_vis[(y + 1) * 4 + x]) m[2] = 1'b1;
                if (x > 0 && y < 4 && !sq_vis[y * 4 + x - 1])   m[3] = 1'b1;
                ed = -1;
                for (int k = 0; k < 4; k++) begin
                    c = (int'(ref_lfsr[1:0]) + k) % 4;
                    if (ed < 0 && m[c]) ed = c;
                end
                chk("sq_dir", int'(sq_if.wr_dir), ed);
                tx = x;
                ty = y;
                case (sq_if.wr_dir)
                    2'd0:    ty = y - 1;
                    2'd1:    tx = x + 1;
                    2'd2:    ty = y + 1;
                    default: tx = x - 1;
                endcase
                fresh = 0;
                if (tx >= 0 && tx < 4 && ty >= 0 && ty < 4) begin
                    fresh = sq_vis[ty * 4 + tx] ? 0 : 1;
                    sq_vis[ty * 4 + tx] = 1'b1;
                end
                chk("sq_target_fresh", fresh, 1);
                act = (x << 6) | (y << 2) | int'(sq_if.wr_dir);
                if (sq_recording) sq_rec.push_back(act);
                if (sq_exp.size() != 0) chk("sq_replay", act, sq_exp.pop_front());
            end
        end
    end

    task automatic sq_start();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) sq_vis[i] = 1'b0;
        sq_vis[0] = 1'b1;
        sq_wr = 0;
        sq_push = 0;
        sq_pop = 0;
        sq_if.start = 1'b1;
        @(negedge clk);
        sq_if.start = 1'b0;
    endtask

    task automatic wait_sq_done(input string name);
        int n;
        n = 0;
        while (!sq_if.done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(sq_if.done), 1);
    endtask

    initial begin : main
        int n, pp, pf, s0;
        rst = 1'b1;
        one_if.start = 1'b0;
        row_if.start = 1'b0;
        sq_if.start  = 1'b0;
        sq_depth     = 5'd16;
        repeat (3) @(negedge clk);
        chk("rst_sq_busy", int'(sq_if.busy), 0);
        chk("rst_sq_done", int'(sq_if.done), 0);
        chk("rst_sq_err", int'(sq_if.err), 0);
        chk("rst_sq_strobes", int'({sq_if.stk_push, sq_if.stk_pop, sq_if.wr_valid}), 0);
        chk("rst_sq_cycles", int'(sq_if.cycles), 0);
        chk("rst_one_done", int'(one_if.done), 0);
        chk("rst_row_busy", int'(row_if.busy), 0);
        rst = 1'b0;

        // 1x1: INIT, PICK, DONE with no strobes.
        @(negedge clk);
        one_if.start = 1'b1;
        @(negedge clk);
        one_if.start = 1'b0;
        n = 1;
        while (!one_if.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("one_latency", n, 3);
        chk("one_done", int'(one_if.done), 1);
        chk("one_wr", one_wr, 0);
        chk("one_push_pop", one_push + one_pop, 0);
        chk("one_cycles", int'(one_if.cycles), CYC_EN ? 2 : 0);

        // 4x1: carve straight east, then back out with three pops.
        row_exp.push_back((0 << 6) | (0 << 2) | 1);
        row_exp.push_back((1 << 6) | (0 << 2) | 1);
        row_exp.push_back((2 << 6) | (0 << 2) | 1);
        row_if.start = 1'b1;
        @(negedge clk);
        row_if.start = 1'b0;
        n = 0;
        while (!row_if.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("row_done", int'(row_if.done), 1);
        chk("row_exp_left", row_exp.size(), 0);
        chk("row_push", row_push, 3);
        chk("row_pop", row_pop, 3);
        chk("row_lifo_empty", int'(row_cnt), 0);
        chk("row_cycles", int'(row_if.cycles), CYC_EN ? 14 : 0);

        // 4x4 full run from reset, recorded for the replay after a mid-run reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sq_recording = 1'b1;
        sq_start();
        wait_sq_done("sq_done");
        sq_recording = 1'b0;
        chk("sq_wr_count", sq_wr, 15);
        chk("sq_push", sq_push, 15);
        chk("sq_pop", sq_pop, 15);
        chk("sq_lifo_empty", int'(sq_if.stk_empty), 1);
        chk("sq_rec_len", sq_rec.size(), 15);
        chk("sq_cycles", int'(sq_if.cycles), CYC_EN ? 62 : 0);
        repeat (3) @(negedge clk);
        chk("sq_cycles_hold", int'(sq_if.cycles), CYC_EN ? 62 : 0);
        chk("sq_busy_after_done", int'(sq_if.busy), 0);

        // Reset ten cycles into a run, then a fresh run must replay the first.
        sq_start();
        repeat (9) @(negedge clk);
        chk("mid_busy_before_rst", int'(sq_if.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(sq_if.busy), 0);
        chk("mid_rst_strobes", int'({sq_if.stk_push, sq_if.stk_pop, sq_if.wr_valid}), 0);
        chk("mid_rst_status", int'({sq_if.done, sq_if.err}), 0);
        chk("mid_rst_cycles", int'(sq_if.cycles), 0);
        rst = 1'b0;
        foreach (sq_rec[i]) sq_exp.push_back(sq_rec[i]);
        sq_start();
        wait_sq_done("replay_done");
        chk("replay_left", sq_exp.size(), 0);
        chk("replay_wr_count", sq_wr, 15);
        chk("replay_push_pop", sq_push - sq_pop, 0);

        // 4x4 with a 4-deep LIFO: overflow on the fifth push attempt.
        sq_depth = 5'd4;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sq_start();
        n  = 0;
        pp = 0;
        pf = 0;
        while (!sq_if.err && n < 500) begin
            pp = int'(sq_if.stk_push);
            pf = int'(sq_if.stk_full);
            @(negedge clk);
            n++;
        end
        chk("err_seen", int'(sq_if.err), 1);
        chk("err_attempt_full", pf, 1);
        chk("err_attempt_no_push", pp, 0);
        chk("err_depth", sq_push - sq_pop, 4);
        chk("err_lifo_cnt", int'(sq_cnt), 4);
        chk("err_busy", int'(sq_if.busy), 0);
        s0 = sq_wr + sq_push + sq_pop;
        sq_if.start = 1'b1;
        @(negedge clk);
        sq_if.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", int'(sq_if.err), 1);
        chk("err_start_ignored", int'({sq_if.busy, sq_if.done}), 0);
        chk("err_no_strobes", sq_wr + sq_push + sq_pop, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
